io_controller: RTL and testbench



---
 rtl/io_controller_pkg.sv | 25 ++
 rtl/io_controller_if.sv | 29 ++
 rtl/io_sync_fifo.sv | 58 +++++
 rtl/io_controller.sv | 175 +++++++++++++++++
 tb/tb_io_controller.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/io_controller_pkg.sv
// Shared types, serializer states and defaults for the io_controller slice.
// IO_WORD_MODE_EN selects 32-bit FIFO entries with byte serialization/assembly.
package io_pkg;

  typedef logic [31:0] io_word_t;
  typedef logic [7:0]  io_byte_t;

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0,
    TX_B0   = 3'd1,
    TX_B1   = 3'd2,
    TX_B2   = 3'd3,
    TX_B3   = 3'd4
  } tx_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int OUT_DEPTH_DEF  = 16;
  localparam int IN_DEPTH_DEF   = 16;

  // Little-endian byte lane select: idx 0 is bits [7:0].
  function automatic io_byte_t word_byte(input io_word_t w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/io_controller_if.sv
// Core-side and UART-side handshake signals of io_controller.
// master = core/UART environment, slave = the controller.
interface io_controller_if;
  import io_pkg::*;

  logic     out_issued;
  io_word_t out_data;
  logic     out_stall;
  logic     in_issued;
  logic     in_stall;
  io_word_t in_data;
  io_byte_t tx_data;
  logic     tx_valid;
  logic     tx_ready;
  io_byte_t rx_data;
  logic     rx_valid;
  logic     rx_overflow;

  modport master (
    output out_issued, out_data, in_issued, tx_ready, rx_data, rx_valid,
    input  out_stall, in_stall, in_data, tx_data, tx_valid, rx_overflow
  );

  modport slave (
    input  out_issued, out_data, in_issued, tx_ready, rx_data, rx_valid,
    output out_stall, in_stall, in_data, tx_data, tx_valid, rx_overflow
  );

endinterface

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with registered full/empty; push is refused when full even if
// a pop happens in the same cycle. DEPTH must be a power of two.
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == CNT_W'(0));
  assign count     = r_count;
  assign rdata     = r_mem[r_rptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= PTR_W'(0);
      r_rptr  <= PTR_W'(0);
      r_count <= CNT_W'(0);
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_controller.sv
// Core I/O responder: TX FIFO drained onto a byte valid/ready link, RX FIFO fed
// by the UART receiver. Define IO_WORD_MODE_EN for 32-bit entries.
module io_controller
  import io_pkg::*;
#(
  parameter int OUT_DEPTH = OUT_DEPTH_DEF,
  parameter int IN_DEPTH  = IN_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  io_controller_if.slave  bus
);

`ifdef IO_WORD_MODE_EN
  localparam int TX_W = 32;
  localparam int RX_W = 32;
`else
  localparam int TX_W = 8;
  localparam int RX_W = 8;
`endif

  logic                       w_tx_push;
  logic                       w_tx_pop;
  logic                       w_tx_full;
  logic                       w_tx_empty;
  logic [TX_W-1:0]            w_tx_head;
  logic [TX_W-1:0]            w_tx_wdata;
  logic [$clog2(OUT_DEPTH):0] w_tx_count;
  logic                       w_tx_valid;
  io_byte_t                   w_tx_data;

  logic                       w_rx_push;
  logic                       w_rx_pop;
  logic                       w_rx_full;
  logic                       w_rx_empty;
  logic [RX_W-1:0]            w_rx_head;
  logic [RX_W-1:0]            w_rx_wdata;
  logic [$clog2(IN_DEPTH):0]  w_rx_count;

  io_word_t                   r_in_data;
  logic                       r_overflow;
  logic                       w_unused;

  assign bus.out_stall   = bus.out_issued & w_tx_full;
  assign bus.in_stall    = bus.in_issued & w_rx_empty;
  assign bus.in_data     = r_in_data;
  assign bus.rx_overflow = r_overflow;
  assign bus.tx_valid    = w_tx_valid;
  assign bus.tx_data     = w_tx_data;

  assign w_tx_push = bus.out_issued & ~w_tx_full;
  assign w_rx_pop  = bus.in_issued & ~w_rx_empty;

  io_sync_fifo #(.WIDTH(TX_W), .DEPTH(OUT_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .wdata (w_tx_wdata),
    .rdata (w_tx_head),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .count (w_tx_count)
  );

  io_sync_fifo #(.WIDTH(RX_W), .DEPTH(IN_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .wdata (w_rx_wdata),
    .rdata (w_rx_head),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .count (w_rx_count)
  );

`ifdef IO_WORD_MODE_EN
  tx_state_t      r_tx_state;
  tx_state_t      w_tx_state_nxt;
  logic [1:0]     r_asm_cnt;
  logic [23:0]    r_asm;

  assign w_tx_wdata = bus.out_data;
  assign w_unused   = ^{w_tx_count, w_rx_count};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_state_nxt;
    end
  end

  // Serializer: walks the head word byte0..byte3, popping it on the last transfer.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_valid     = 1'b1;
    w_tx_data      = 8'h00;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_valid = 1'b0;
        if (!w_tx_empty) w_tx_state_nxt = TX_B0;
        else             w_tx_state_nxt = TX_IDLE;
      end
      TX_B0: begin
        w_tx_data = word_byte(w_tx_head, 2'd0);
        if (bus.tx_ready) w_tx_state_nxt = TX_B1;
        else              w_tx_state_nxt = TX_B0;
      end
      TX_B1: begin
        w_tx_data = word_byte(w_tx_head, 2'd1);
        if (bus.tx_ready) w_tx_state_nxt = TX_B2;
        else              w_tx_state_nxt = TX_B1;
      end
      TX_B2: begin
        w_tx_data = word_byte(w_tx_head, 2'd2);
        if (bus.tx_ready) w_tx_state_nxt = TX_B3;
        else              w_tx_state_nxt = TX_B2;
      end
      TX_B3: begin
        w_tx_data = word_byte(w_tx_head, 2'd3);
        if (bus.tx_ready) begin
          w_tx_pop       = 1'b1;
          w_tx_state_nxt = TX_IDLE;
        end else begin
          w_tx_state_nxt = TX_B3;
        end
      end
      default: begin
        w_tx_valid     = 1'b0;
        w_tx_state_nxt = TX_IDLE;
      end
    endcase
  end

  // Assembler keeps the three earlier bytes; the fourth completes the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm_cnt <= 2'd0;
      r_asm     <= 24'h000000;
    end else if (bus.rx_valid) begin
      r_asm_cnt <= r_asm_cnt + 2'd1;
      r_asm     <= {bus.rx_data, r_asm[23:8]};
    end else begin
      r_asm_cnt <= r_asm_cnt;
      r_asm     <= r_asm;
    end
  end

  assign w_rx_push  = bus.rx_valid & (r_asm_cnt == 2'(BYTES_PER_WORD - 1));
  assign w_rx_wdata = {bus.rx_data, r_asm};
`else
  assign w_tx_wdata = bus.out_data[7:0];
  assign w_tx_valid = ~w_tx_empty;
  assign w_tx_data  = w_tx_empty ? 8'h00 : w_tx_head;
  assign w_tx_pop   = w_tx_valid & bus.tx_ready;
  assign w_rx_push  = bus.rx_valid;
  assign w_rx_wdata = bus.rx_data;
  assign w_unused   = ^{w_tx_count, w_rx_count, bus.out_data[31:8]};
`endif

  // Overflow is sticky until reset; in_data holds until the next accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_in_data  <= 32'h0000_0000;
    end else begin
      if (w_rx_push & w_rx_full) r_overflow <= 1'b1;
      if (w_rx_pop)              r_in_data  <= io_word_t'(w_rx_head);
    end
  end

endmodule

// File: tb/tb_io_controller.sv
// Randomized self-checking bench for io_controller against a queue-based model;
// covers byte mode by default and IO_WORD_MODE_EN when defined.
module tb_io_controller;

  localparam int OUT_DEPTH = 16;
  localparam int IN_DEPTH  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_controller_if bus();

  io_controller #(.OUT_DEPTH(OUT_DEPTH), .IN_DEPTH(IN_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_tx_q[$];
  logic [7:0]  m_tx_bytes[$];
  int          m_tx_sent;
  logic [31:0] m_rx_q[$];
  logic [7:0]  m_asm[$];
  logic [31:0] m_in_data;
  logic        m_ovf;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tx_q.delete();
    m_tx_bytes.delete();
    m_tx_sent = 0;
    m_rx_q.delete();
    m_asm.delete();
    m_in_data = 32'h0;
    m_ovf     = 1'b0;
  endtask

  task automatic drive(input logic oi, input logic [31:0] od, input logic ii,
                       input logic tr, input logic rv, input logic [7:0] rd);
    bus.out_issued = oi;
    bus.out_data   = od;
    bus.in_issued  = ii;
    bus.tx_ready   = tr;
    bus.rx_valid   = rv;
    bus.rx_data    = rd;
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic step();
    logic tx_full, rx_empty, rx_full;
    #1;
    tx_full  = (m_tx_q.size() == OUT_DEPTH);
    rx_empty = (m_rx_q.size() == 0);
    rx_full  = (m_rx_q.size() == IN_DEPTH);
    check_val("out_stall", bus.out_stall, bus.out_issued & tx_full);
    check_val("in_stall", bus.in_stall, bus.in_issued & rx_empty);
    check_val("in_data", bus.in_data, m_in_data);
    check_val("rx_overflow", bus.rx_overflow, m_ovf);
`ifdef IO_WORD_MODE_EN
    if (m_tx_q.size() == 0) check_val("tx_idle", bus.tx_valid, 1'b0);
`else
    check_val("tx_valid", bus.tx_valid, m_tx_q.size() != 0);
    check_val("tx_data", bus.tx_data, (m_tx_q.size() != 0) ? m_tx_q[0] & 32'hFF : 32'h0);
`endif
    if (bus.tx_valid && bus.tx_ready) begin
      if (m_tx_bytes.size() == 0) begin
        check_val("tx_spurious", bus.tx_valid, 1'b0);
      end else begin
        check_val("tx_byte", bus.tx_data, m_tx_bytes.pop_front());
        m_tx_sent++;
`ifdef IO_WORD_MODE_EN
        if (m_tx_sent % 4 == 0) void'(m_tx_q.pop_front());
`else
        void'(m_tx_q.pop_front());
`endif
      end
    end
    if (bus.out_issued && !tx_full) begin
`ifdef IO_WORD_MODE_EN
      m_tx_q.push_back(bus.out_data);
      for (int b = 0; b < 4; b++) m_tx_bytes.push_back(8'((bus.out_data >> (8 * b)) & 32'hFF));
`else
      m_tx_q.push_back(bus.out_data & 32'hFF);
      m_tx_bytes.push_back(bus.out_data[7:0]);
`endif
    end
    if (bus.in_issued && !rx_empty) m_in_data = m_rx_q.pop_front();
    if (bus.rx_valid) begin
`ifdef IO_WORD_MODE_EN
      m_asm.push_back(bus.rx_data);
      if (m_asm.size() == 4) begin
        if (rx_full) m_ovf = 1'b1;
        else m_rx_q.push_back({m_asm[3], m_asm[2], m_asm[1], m_asm[0]});
        m_asm.delete();
      end
`else
      if (rx_full) m_ovf = 1'b1;
      else m_rx_q.push_back({24'h0, bus.rx_data});
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    @(posedge clk);
    @(negedge clk);
    check_val("rst_tx_valid", bus.tx_valid, 1'b0);
    check_val("rst_tx_data", bus.tx_data, 8'h00);
    check_val("rst_in_data", bus.in_data, 32'h0);
    check_val("rst_overflow", bus.rx_overflow, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int p_out, p_in, p_rdy, p_rx;
    do_reset();
    step();

    // Single output byte with tx_ready high.
    drive(1'b1, 32'h41, 1'b0, 1'b1, 1'b0, 8'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    repeat (6) step();

    // Fill TX with ready low, 17th stalls, one ready cycle releases it.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 8'h0);
      step();
    end
    drive(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 8'h0);
    step();
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 8'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    repeat (90) step();

    // Read with RX empty; same-cycle rx_valid must not satisfy it.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 8'h5A);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    repeat (6) step();

    // Overflow RX, then read everything back.
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 8'($urandom));
      step();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h0);
    repeat (18) step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    step();

    // Reset while a byte is presented and not accepted.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0, 8'h0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    step();
    check_val("pre_rst_tx_valid", bus.tx_valid, 1'b1);
    do_reset();
    drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b0, 8'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    repeat (8) step();

`ifdef IO_WORD_MODE_EN
    drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 8'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    repeat (8) step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h78); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h56); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h34); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h12); step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h0);  step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);  step();
    check_val("word_in_data", bus.in_data, 32'h12345678);
`endif

    // Random traffic with biases that move through full and empty regimes.
    for (int ph = 0; ph < 8; ph++) begin
      p_out = $urandom_range(10, 90);
      p_in  = $urandom_range(10, 90);
      p_rdy = $urandom_range(5, 95);
      p_rx  = $urandom_range(10, 90);
      for (int c = 0; c < 500; c++) begin
        drive($urandom_range(0, 99) < p_out, $urandom, $urandom_range(0, 99) < p_in,
              $urandom_range(0, 99) < p_rdy, $urandom_range(0, 99) < p_rx, 8'($urandom));
        step();
      end
    end

    // Drain, bounded.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    for (int c = 0; c < 300 && m_tx_q.size() != 0; c++) step();
    step();
    check_val("drained_tx_valid", bus.tx_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
